// File: rtl/alu_rr_sched.sv
// rtl/alu_rr_sched.sv - two-requester round-robin scheduler around a shared 4-bit ALU
module alu_rr_sched #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_y,
    output logic             rsp_cout,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic [1:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       cin_q;
    logic       id_q;
    logic       accept_ok;
    logic       accept;
    logic       gnt_id;
    logic [4:0] alu_res;

    assign rsp_valid = (state == RESP);

    // A response slot frees up in the same cycle the consumer takes the result.
    always_comb begin
        state_nxt  = state;
        accept_ok  = (state == IDLE) || ((state == RESP) && rsp_ready);
        gnt_id     = (req0_valid && req1_valid) ? !last_grant : req1_valid;
        accept     = accept_ok && (req0_valid || req1_valid);
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
        case (state)
            IDLE: if (accept) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = accept ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op_q)
            2'b00:   alu_res = {1'b0, a_q} + {1'b0, b_q} + {4'b0000, cin_q};
            2'b01:   alu_res = {1'b0, a_q} - {1'b0, b_q} - {4'b0000, cin_q};
            2'b10:   alu_res = {1'b0, ~(a_q & b_q)};
            default: alu_res = {1'b0, ~(a_q | b_q)};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_y      <= '0;
            rsp_cout   <= 1'b0;
            done_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q       <= gnt_id ? req1_op  : req0_op;
                a_q        <= gnt_id ? req1_a   : req0_a;
                b_q        <= gnt_id ? req1_b   : req0_b;
                cin_q      <= gnt_id ? req1_cin : req0_cin;
                id_q       <= gnt_id;
                last_grant <= gnt_id;
            end
            if (state == EXEC) begin
                rsp_y    <= alu_res[3:0];
                rsp_cout <= alu_res[4];
                rsp_id   <= id_q;
            end
            if (rsp_valid && rsp_ready) done_cnt <= done_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb/tb_alu_rr_sched.sv - scoreboard bench for alu_rr_sched
module tb_alu_rr_sched;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    typedef struct {
        logic       id;
        logic [4:0] res;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_cin;
    logic [1:0] req0_op;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_cin;
    logic [1:0] req1_op;
    logic [3:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [3:0] rsp_y;
    logic [7:0] done_cnt;

    exp_t       exp_q[$];
    logic [7:0] exp_cnt = '0;
    logic       m_last = 1'b1;
    int         hs_count = 0;
    int         n_vec = 0;
    int         n_err = 0;

    alu_rr_sched #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_cout(rsp_cout), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_alu(input logic [1:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic cin);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b} + {4'b0000, cin};
            OP_SUB:  return {1'b0, a} - {1'b0, b} - {4'b0000, cin};
            OP_NAND: return {1'b0, ~(a & b)};
            default: return {1'b0, ~(a | b)};
        endcase
    endfunction

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            exp_cnt = '0;
            m_last  = 1'b1;
        end else begin
            check("done_cnt", done_cnt, exp_cnt);
            check("one_ready", req0_ready && req1_ready, 0);
            check("rdy0_no_valid", req0_ready && !req0_valid, 0);
            check("rdy1_no_valid", req1_ready && !req1_valid, 0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_id", rsp_id, e.id);
                    check("sb_y", rsp_y, e.res[3:0]);
                    check("sb_cout", rsp_cout, e.res[4]);
                end
                exp_cnt = exp_cnt + 8'd1;
                hs_count++;
            end
            if (req0_valid && req1_valid && (req0_ready || req1_ready))
                check("rr_grant", req1_ready, !m_last);
            if (req0_valid && req0_ready) begin
                exp_q.push_back('{id: 1'b0, res: ref_alu(req0_op, req0_a, req0_b, req0_cin)});
                m_last = 1'b0;
            end else if (req1_valid && req1_ready) begin
                exp_q.push_back('{id: 1'b1, res: ref_alu(req1_op, req1_a, req1_b, req1_cin)});
                m_last = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive0(input logic v, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic c);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_cin = c;
    endtask

    task automatic drive1(input logic v, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic c);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_cin = c;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check({tag, "_timeout"}, rsp_valid, 1);
    endtask

    task automatic issue1(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] ey, input logic ec);
        drive1(1'b1, op, a, b, 1'b0);
        step();
        req1_valid = 1'b0;
        wait_rsp("t3");
        check("t3_id", rsp_id, 1);
        check("t3_y", rsp_y, ey);
        check("t3_cout", rsp_cout, ec);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int cyc;
        logic [31:0] r;
        rst = 1'b1;
        rsp_ready = 1'b0;
        drive0(1'b0, OP_ADD, 4'h0, 4'h0, 1'b0);
        drive1(1'b0, OP_ADD, 4'h0, 4'h0, 1'b0);

        // reset state and first add
        do_reset();
        @(negedge clk);
        check("rst_valid", rsp_valid, 0);
        check("rst_id", rsp_id, 0);
        check("rst_y", rsp_y, 0);
        check("rst_cout", rsp_cout, 0);
        check("rst_cnt", done_cnt, 0);
        step();
        rsp_ready = 1'b1;
        drive0(1'b1, OP_ADD, 4'b0011, 4'b0101, 1'b0);
        @(negedge clk);
        check("t1_rdy0", req0_ready, 1);
        check("t1_rdy1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        check("t1_exec_valid", rsp_valid, 0);
        step();
        @(negedge clk);
        check("t1_valid", rsp_valid, 1);
        check("t1_id", rsp_id, 0);
        check("t1_y", rsp_y, 4'b1000);
        check("t1_cout", rsp_cout, 0);
        step();
        @(negedge clk);
        check("t1_cnt", done_cnt, 1);
        check("t1_idle", rsp_valid, 0);

        // tie from reset, back-to-back alternation
        do_reset();
        rsp_ready = 1'b1;
        drive0(1'b1, OP_ADD, 4'b1111, 4'b0001, 1'b1);
        drive1(1'b1, OP_SUB, 4'b0001, 4'b0011, 1'b0);
        @(negedge clk);
        check("t2_rdy0", req0_ready, 1);
        check("t2_rdy1", req1_ready, 0);
        step();
        @(negedge clk);
        check("t2_exec_rdy", req0_ready || req1_ready, 0);
        step();
        @(negedge clk);
        check("t2_r0_id", rsp_id, 0);
        check("t2_r0_y", rsp_y, 4'b0001);
        check("t2_r0_cout", rsp_cout, 1);
        check("t2_b2b_rdy1", req1_ready, 1);
        step();
        step();
        @(negedge clk);
        check("t2_r1_id", rsp_id, 1);
        check("t2_r1_y", rsp_y, 4'b1110);
        check("t2_r1_cout", rsp_cout, 1);
        check("t2_next_tie", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp("t2");
        check("t2_r2_id", rsp_id, 0);
        step();

        // logic ops
        issue1(OP_NAND, 4'b1100, 4'b1010, 4'b0111, 1'b0);
        issue1(OP_NOR, 4'b1100, 4'b1010, 4'b0001, 1'b0);

        // backpressure
        rsp_ready = 1'b0;
        drive0(1'b1, OP_ADD, 4'b0110, 4'b0111, 1'b1);
        step();
        req0_valid = 1'b0;
        drive1(1'b1, OP_SUB, 4'b0101, 4'b0010, 1'b1);
        wait_rsp("t4");
        for (int i = 0; i < 5; i++) begin
            check("t4_valid", rsp_valid, 1);
            check("t4_id", rsp_id, 0);
            check("t4_y", rsp_y, 4'b1110);
            check("t4_cout", rsp_cout, 0);
            check("t4_rdy", req0_ready || req1_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_rdy1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        wait_rsp("t4b");
        check("t4b_id", rsp_id, 1);
        check("t4b_y", rsp_y, 4'b0010);
        check("t4b_cout", rsp_cout, 0);
        step();

        // reset with an operation in EXEC
        drive0(1'b1, OP_ADD, 4'b0001, 4'b0001, 1'b0);
        step();
        req0_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t5_valid", rsp_valid, 0);
        check("t5_cnt", done_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_stale", rsp_valid, 0);
        end
        step();
        drive0(1'b1, OP_NOR, 4'b0000, 4'b0000, 1'b0);
        drive1(1'b1, OP_NAND, 4'b1111, 4'b1111, 1'b0);
        @(negedge clk);
        check("t5_tie_rdy0", req0_ready, 1);
        check("t5_tie_rdy1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp("t5");
        check("t5_id", rsp_id, 0);
        step();

        // 256 back-to-back operations, counter wrap
        do_reset();
        base = hs_count;
        cyc = 0;
        rsp_ready = 1'b1;
        while ((hs_count - base) < 256 && cyc < 3000) begin
            r = $urandom;
            drive0(1'b1, r[1:0], r[5:2], r[9:6], r[10]);
            drive1(1'b1, r[12:11], r[16:13], r[20:17], r[21]);
            step();
            cyc++;
        end
        check("t6_ops", hs_count - base, 256);
        @(negedge clk);
        check("t6_wrap", done_cnt, 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        step();
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
